// File: rtl/aes_input_packer_pkg.sv
// Shared AES feeder definitions: block/word geometry and word-lane ordering.
// Lane 0 is the first word of a block and occupies the most significant bits.
package aes_input_packer_pkg;

    localparam int unsigned AES_BLOCK_W       = 128;
    localparam int unsigned AES_WORD_W        = 32;
    localparam int unsigned AES_WORDS_PER_BLK = 4;

    typedef logic [AES_BLOCK_W-1:0] blk_t;
    typedef logic [AES_WORD_W-1:0]  word_t;

    typedef enum logic [1:0] {
        LANE_0 = 2'd0,
        LANE_1 = 2'd1,
        LANE_2 = 2'd2,
        LANE_3 = 2'd3
    } lane_t;

    function automatic blk_t place_word(input blk_t blk, input lane_t lane, input word_t w);
        blk_t r;
        r = blk;
        case (lane)
            LANE_0:  r[AES_BLOCK_W-1                -: AES_WORD_W] = w;
            LANE_1:  r[AES_BLOCK_W-1-AES_WORD_W     -: AES_WORD_W] = w;
            LANE_2:  r[AES_BLOCK_W-1-2*AES_WORD_W   -: AES_WORD_W] = w;
            default: r[AES_WORD_W-1                 -: AES_WORD_W] = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO with registered wrap-bit pointers.
// A push while full is honoured when a pop happens in the same cycle.
module aes_blk_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
        do_pop   = pop & ~empty;
        do_push  = push & (~full | pop);
        pop_data = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/aes_input_packer.sv
// Packs 32-bit words into 128-bit AES blocks, queues them and issues them under a credit cap.
// Optional AES_PACK_PAD_EN: s_last zero-fills and pushes a partial block.
module aes_input_packer
    import aes_input_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_last,
    input  logic         key_load,
    input  logic [127:0] key_data,
    output logic         key_err,
    output logic         aes_start,
    output logic [127:0] aes_key,
    output logic [127:0] aes_pt,
    input  logic         aes_valid,
    output logic         busy
);

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    lane_t      wc_q;
    blk_t       pack_q;
    blk_t       blk_next;
    blk_t       fifo_head;
    logic [3:0] outst_q;
    logic       fifo_full;
    logic       fifo_empty;
    logic       accept;
    logic       last_word;
    logic       issue;
    logic       key_accept;
    logic       credit_ret;

`ifndef AES_PACK_PAD_EN
    logic unused_s_last;
    assign unused_s_last = s_last;
`endif

    always_comb begin
        s_ready    = rstn & ~fifo_full;
        accept     = s_valid & s_ready;
        blk_next   = place_word(pack_q, wc_q, s_data);
`ifdef AES_PACK_PAD_EN
        last_word  = (wc_q == LANE_3) | s_last;
`else
        last_word  = (wc_q == LANE_3);
`endif
        busy       = (wc_q != LANE_0) | ~fifo_empty | (outst_q != '0);
        key_accept = key_load & ~busy & ~s_valid;
        issue      = ~fifo_empty & (outst_q < MAX_OUT) & ~key_accept;
        credit_ret = aes_valid & (outst_q != '0);
    end

    aes_blk_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AES_BLOCK_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (accept & last_word),
        .push_data (blk_next),
        .pop       (issue),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Lanes past the current word stay zero, so blk_next doubles as the padded block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wc_q   <= LANE_0;
            pack_q <= '0;
        end else if (accept) begin
            if (last_word) begin
                wc_q   <= LANE_0;
                pack_q <= '0;
            end else begin
                wc_q   <= lane_t'(wc_q + 2'd1);
                pack_q <= blk_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outst_q   <= '0;
            aes_start <= 1'b0;
            aes_pt    <= '0;
            aes_key   <= '0;
            key_err   <= 1'b0;
        end else begin
            case ({issue, credit_ret})
                2'b10:   outst_q <= outst_q + 4'd1;
                2'b01:   outst_q <= outst_q - 4'd1;
                default: outst_q <= outst_q;
            endcase
            aes_start <= issue;
            if (issue)      aes_pt  <= fifo_head;
            if (key_accept) aes_key <= key_data;
            key_err <= key_load & ~key_accept;
        end
    end

endmodule

// File: tb/tb_aes_input_packer.sv
// Directed bench for aes_input_packer (default parameters; honours AES_PACK_PAD_EN if defined).
module tb_aes_input_packer;

    logic         clk = 1'b0;
    logic         rstn;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic         key_load;
    logic [127:0] key_data;
    logic         key_err;
    logic         aes_start;
    logic [127:0] aes_key;
    logic [127:0] aes_pt;
    logic         aes_valid;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] K2 = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [127:0] K3 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;

    aes_input_packer u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .key_load  (key_load),
        .key_data  (key_data),
        .key_err   (key_err),
        .aes_start (aes_start),
        .aes_key   (aes_key),
        .aes_pt    (aes_pt),
        .aes_valid (aes_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (aes_start === 1'b1) start_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_word(input logic [31:0] d, input logic last);
        logic ok;
        ok = 1'b0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (s_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        s_last = 1'b0;
        chk("put_word_accept", 128'(ok), 128'd1);
    endtask

    task automatic put_block(input logic [127:0] b);
        put_word(b[127:96], 1'b0);
        put_word(b[95:64], 1'b0);
        put_word(b[63:32], 1'b0);
        put_word(b[31:0], 1'b0);
        s_valid = 1'b0;
    endtask

    task automatic pulse_valid();
        aes_valid = 1'b1;
        @(negedge clk);
        aes_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; s_valid = 1'b0; aes_valid = 1'b0; key_load = 1'b0; s_last = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base;
        logic found;
        rstn = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        key_load = 1'b0; key_data = '0; aes_valid = 1'b0;
        #1 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_s_ready", 128'(s_ready), 128'd0);
        chk("rst_aes_start", 128'(aes_start), 128'd0);
        chk("rst_aes_key", aes_key, '0);
        chk("rst_aes_pt", aes_pt, '0);
        chk("rst_busy", 128'(busy), 128'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", 128'(s_ready), 128'd1);

        // FIPS-197 key and plaintext, with start latency
        key_load = 1'b1; key_data = K1;
        @(negedge clk);
        key_load = 1'b0;
        chk("key_idle_load", aes_key, K1);
        chk("key_idle_err", 128'(key_err), 128'd0);
        put_word(32'h00112233, 1'b0);
        put_word(32'h44556677, 1'b0);
        put_word(32'h8899AABB, 1'b0);
        put_word(32'hCCDDEEFF, 1'b0);
        s_valid = 1'b0;
        chk("lat_no_start_yet", 128'(aes_start), 128'd0);
        chk("lat_busy", 128'(busy), 128'd1);
        @(negedge clk);
        chk("lat_start", 128'(aes_start), 128'd1);
        chk("fips_pt", aes_pt, 128'h00112233445566778899AABBCCDDEEFF);
        @(negedge clk);
        chk("start_one_cycle", 128'(aes_start), 128'd0);
        chk("fips_start_cnt", 128'(start_cnt), 128'd1);
        pulse_valid();
        chk("idle_after_valid", 128'(busy), 128'd0);

        // Credit: stray aes_valid ignored, coincident valid/issue keeps cap
        pulse_valid();
        put_block(128'h10000000_10000001_10000002_10000003);
        put_block(128'h20000000_20000001_20000002_20000003);
        wait_n(3);
        chk("stray_valid_starts", 128'(start_cnt), 128'd2);
        chk("stray_valid_pt", aes_pt, 128'h10000000_10000001_10000002_10000003);

        key_load = 1'b1; key_data = K2;
        @(negedge clk);
        key_load = 1'b0;
        chk("key_busy_err", 128'(key_err), 128'd1);
        chk("key_busy_keep", aes_key, K1);
        @(negedge clk);
        chk("key_err_pulse", 128'(key_err), 128'd0);

        aes_valid = 1'b1;
        wait_n(2);
        aes_valid = 1'b0;
        chk("coinc_starts", 128'(start_cnt), 128'd3);
        chk("coinc_pt", aes_pt, 128'h20000000_20000001_20000002_20000003);
        put_block(128'h30000000_30000001_30000002_30000003);
        wait_n(4);
        chk("coinc_no_extra", 128'(start_cnt), 128'd3);
        pulse_valid();
        wait_n(2);
        chk("credit_start", 128'(start_cnt), 128'd4);
        chk("credit_pt", aes_pt, 128'h30000000_30000001_30000002_30000003);
        pulse_valid();
        @(negedge clk);
        chk("idle_again", 128'(busy), 128'd0);
        key_load = 1'b1; key_data = K3;
        @(negedge clk);
        key_load = 1'b0;
        chk("key_reload", aes_key, K3);

        // Back-pressure with a single credit
        do_reset();
        base = start_cnt;
        for (int w = 0; w < 20; w++) put_word(32'hA0000000 + 32'(w), 1'b0);
        s_data = 32'hA0000014;
        chk("full_s_ready", 128'(s_ready), 128'd0);
        wait_n(3);
        chk("full_s_ready_hold", 128'(s_ready), 128'd0);
        chk("full_one_start", 128'(start_cnt - base), 128'd1);
        pulse_valid();
        found = 1'b0;
        for (int k = 0; k < 2 && !found; k++) begin
            if (start_cnt - base == 2) found = 1'b1;
            else @(negedge clk);
        end
        if (start_cnt - base == 2) found = 1'b1;
        s_valid = 1'b0;
        chk("full_next_start", 128'(found), 128'd1);
        chk("full_pt2", aes_pt, 128'hA0000004_A0000005_A0000006_A0000007);
        chk("full_s_ready_back", 128'(s_ready), 128'd1);

        // Reset mid-block discards the partial words
        do_reset();
        put_word(32'hDEAD0001, 1'b0);
        put_word(32'hDEAD0002, 1'b0);
        s_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mid_rst_s_ready", 128'(s_ready), 128'd0);
        chk("mid_rst_pt", aes_pt, '0);
        chk("mid_rst_key", aes_key, '0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        base = start_cnt;
        put_block(128'h01234567_89ABCDEF_FEDCBA98_76543210);
        wait_n(2);
        chk("post_rst_starts", 128'(start_cnt - base), 128'd1);
        chk("post_rst_pt", aes_pt, 128'h01234567_89ABCDEF_FEDCBA98_76543210);

        // s_last on a partial block
        do_reset();
        base = start_cnt;
        put_word(32'hAABBCCDD, 1'b0);
        put_word(32'h11223344, 1'b1);
        s_valid = 1'b0;
        wait_n(3);
`ifdef AES_PACK_PAD_EN
        chk("pad_start", 128'(start_cnt - base), 128'd1);
        chk("pad_pt", aes_pt, 128'hAABBCCDD_11223344_00000000_00000000);
`else
        chk("nopad_no_start", 128'(start_cnt - base), 128'd0);
        chk("nopad_busy", 128'(busy), 128'd1);
        put_word(32'h55667788, 1'b0);
        put_word(32'h99AABBCC, 1'b0);
        s_valid = 1'b0;
        wait_n(2);
        chk("nopad_start", 128'(start_cnt - base), 128'd1);
        chk("nopad_pt", aes_pt, 128'hAABBCCDD_11223344_55667788_99AABBCC);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
